// File: rtl/pb_debounce_multi_if.sv
// Push-button conditioner bus.
//   PB         : raw button inputs, asynchronous to the consumer clock
//   level      : debounced state, 1 = pressed
//   pressed    : one-cycle pulse on level 0->1
//   released   : one-cycle pulse on level 1->0
//   long_press : one-cycle pulse when a hold reaches the long-press length
//   held_long  : high from long_press until release
// master = board/button side (drives PB), slave = conditioner.
interface pb_debounce_multi_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] PB;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] released;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] held_long;

    modport master (output PB, input level, pressed, released, long_press, held_long);
    modport slave  (input PB, output level, pressed, released, long_press, held_long);
endinterface

// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button conditioner: per channel a 2-flop synchroniser,
// a stability-counter debouncer and registered press/release/long-press pulses.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pb_debounce_multi_if.slave (PB in; level/pressed/released/
//           long_press/held_long out), bit i belongs to channel i

// One button channel.
module pb_debounce_ch #(
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 25_000_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic level,
    output logic pressed,
    output logic released,
    output logic long_press,
    output logic held_long
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int LW  = $clog2(LONG_CYCLES + 1);
    localparam logic INACT = ACTIVE_LOW;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [LW-1:0]  LMAX    = LW'(LONG_CYCLES);

    logic           sync1, sync2, s;
    logic           toggle, level_nx, long_hit;
    logic [DBW-1:0] db_cnt, db_cnt_nx;
    logic [LW-1:0]  hold_cnt, hold_cnt_nx;

    // Normalise to 1 = pressed.
    assign s = sync2 ^ INACT;

    always_comb begin
        toggle      = 1'b0;
        db_cnt_nx   = '0;
        hold_cnt_nx = '0;
        long_hit    = 1'b0;
        if (s != level) begin
            if (db_cnt == DB_LAST) toggle = 1'b1;
            else                   db_cnt_nx = db_cnt + 1'b1;
        end
        level_nx = level ^ toggle;
        // The hold counter reads 0 in every cycle where level is low or the
        // press pulse is showing, so it holds LONG_CYCLES exactly LONG_CYCLES
        // edges after the press edge. A release toggle forces level_nx low,
        // which is what makes a simultaneous release beat the long press.
        if (level_nx && !toggle) begin
            if (hold_cnt != LMAX) begin
                hold_cnt_nx = hold_cnt + 1'b1;
                long_hit    = (hold_cnt_nx == LMAX);
            end else begin
                hold_cnt_nx = hold_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= INACT;
            sync2      <= INACT;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            level      <= 1'b0;
            pressed    <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
            held_long  <= 1'b0;
        end else begin
            sync1      <= pb;
            sync2      <= sync1;
            db_cnt     <= db_cnt_nx;
            hold_cnt   <= hold_cnt_nx;
            level      <= level_nx;
            pressed    <= toggle & level_nx;
            released   <= toggle & ~level_nx;
            long_press <= long_hit;
            held_long  <= level_nx & (held_long | long_hit);
        end
    end
endmodule

module pb_debounce_multi #(
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 25_000_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    pb_debounce_multi_if.slave bus
);
    logic [N_BTN-1:0] level_w, pressed_w, released_w, long_w, held_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        pb_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pb        (bus.PB[i]),
            .level     (level_w[i]),
            .pressed   (pressed_w[i]),
            .released  (released_w[i]),
            .long_press(long_w[i]),
            .held_long (held_w[i])
        );
    end

    assign bus.level      = level_w;
    assign bus.pressed    = pressed_w;
    assign bus.released   = released_w;
    assign bus.long_press = long_w;
    assign bus.held_long  = held_w;
endmodule

// File: tb/tb_pb_debounce_multi.sv
// Bench for pb_debounce_multi (N_BTN=2, DB_CYCLES=4, LONG_CYCLES=10,
// ACTIVE_LOW=1): directed scenarios plus random button activity, every cycle
// compared against a reference model built from run lengths and edge stamps.
module tb_pb_debounce_multi;
    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int LONG = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pb_debounce_multi_if #(.N_BTN(N)) bus ();

    pb_debounce_multi #(
        .N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: two-cycle input delay, run length of disagreement,
    // press edge stamp for the long-press deadline.
    bit     m_h1[N], m_h2[N], m_lvl[N];
    bit     m_pr[N], m_rl[N], m_lp[N], m_hl[N];
    int     m_run[N];
    longint m_pedge[N];
    longint cyc;
    int     lp_seen[N], pr_seen[N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_h1[c] = 0; m_h2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
            m_pr[c] = 0; m_rl[c] = 0; m_lp[c] = 0; m_hl[c] = 0;
            m_pedge[c] = -1000;
        end
        cyc = 0;
    endtask

    task automatic model_step();
        bit s;
        cyc++;
        for (int c = 0; c < N; c++) begin
            s = m_h2[c];
            m_h2[c] = m_h1[c];
            m_h1[c] = !bus.PB[c];
            m_pr[c] = 0; m_rl[c] = 0; m_lp[c] = 0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                    if (s) begin m_pr[c] = 1; m_pedge[c] = cyc; end
                    else   begin m_rl[c] = 1; m_hl[c] = 0; end
                end
            end else begin
                m_run[c] = 0;
            end
            if (m_lvl[c] && (cyc - m_pedge[c] == LONG)) begin
                m_lp[c] = 1; m_hl[c] = 1;
            end
        end
    endtask

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = a[c];
        return v;
    endfunction

    task automatic compare_all();
        chk("level",      int'(bus.level),      int'(pack(m_lvl)));
        chk("pressed",    int'(bus.pressed),    int'(pack(m_pr)));
        chk("released",   int'(bus.released),   int'(pack(m_rl)));
        chk("long_press", int'(bus.long_press), int'(pack(m_lp)));
        chk("held_long",  int'(bus.held_long),  int'(pack(m_hl)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
        for (int c = 0; c < N; c++) begin
            if (bus.long_press[c]) lp_seen[c]++;
            if (bus.pressed[c])    pr_seen[c]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // kind: 0 pressed, 1 released, 2 long_press. n = ticks until seen, -1 on timeout.
    task automatic wait_bit(input int kind, input int ch, output int n);
        logic [N-1:0] v;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            v = (kind == 0) ? bus.pressed : (kind == 1) ? bus.released : bus.long_press;
            if (v[ch]) begin n = i; break; end
        end
    endtask

    task automatic clear_seen();
        for (int c = 0; c < N; c++) begin lp_seen[c] = 0; pr_seen[c] = 0; end
    endtask

    int n;
    int rem[N];

    initial begin
        rst_n  = 1'b0;
        bus.PB = 2'b11;
        model_reset();
        clear_seen();

        // Reset / idle
        ticks(3);
        chk("rst_outputs", int'({bus.level, bus.pressed, bus.released, bus.long_press, bus.held_long}), 0);
        rst_n = 1'b1;
        ticks(50);

        // Clean press / release on channel 0
        bus.PB[0] = 1'b0;
        wait_bit(0, 0, n);
        chk("press_latency", n, DB + 2);
        chk("level0_after_press", int'(bus.level[0]), 1);
        tick();
        chk("press_pulse_width", int'(bus.pressed[0]), 0);
        ticks(18);
        bus.PB[0] = 1'b1;
        wait_bit(1, 0, n);
        chk("release_latency", n, DB + 2);
        chk("level0_after_release", int'(bus.level[0]), 0);
        ticks(10);

        // Bounce rejection: 3 low, 1 high, 3 low, high
        clear_seen();
        bus.PB[0] = 1'b0; ticks(3);
        bus.PB[0] = 1'b1; ticks(1);
        bus.PB[0] = 1'b0; ticks(3);
        bus.PB[0] = 1'b1; ticks(10);
        chk("bounce_no_press", pr_seen[0], 0);
        // 4 cycles low is accepted
        bus.PB[0] = 1'b0; ticks(4);
        bus.PB[0] = 1'b1; ticks(12);
        chk("four_low_accepted", pr_seen[0], 1);

        // Long press on channel 1
        clear_seen();
        bus.PB[1] = 1'b0;
        wait_bit(0, 1, n);
        chk("press1_latency", n, DB + 2);
        wait_bit(2, 1, n);
        chk("long_latency", n, LONG);
        chk("held_long_set", int'(bus.held_long[1]), 1);
        ticks(100);
        chk("long_once", lp_seen[1], 1);
        bus.PB[1] = 1'b1;
        wait_bit(1, 1, n);
        chk("held_clear_on_release", int'(bus.held_long[1]), 0);
        ticks(10);

        // Short press: released 9 cycles after pressed
        clear_seen();
        bus.PB[0] = 1'b0;
        wait_bit(0, 0, n);
        ticks(3);
        bus.PB[0] = 1'b1;
        wait_bit(1, 0, n);
        chk("short_release_gap", n, 6);
        ticks(15);
        chk("short_no_long", lp_seen[0], 0);

        // Release edge coincides with the long-press deadline
        clear_seen();
        bus.PB[0] = 1'b0;
        wait_bit(0, 0, n);
        ticks(4);
        bus.PB[0] = 1'b1;
        wait_bit(1, 0, n);
        chk("boundary_release_gap", n, 6);
        ticks(15);
        chk("boundary_no_long", lp_seen[0], 0);

        // Channel 0 pressed while channel 1 bounces
        clear_seen();
        bus.PB[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.PB[1] = (i % 4 < 2);
            tick();
        end
        bus.PB[1] = 1'b1;
        chk("ch1_quiet", pr_seen[1], 0);
        chk("ch0_pressed", pr_seen[0], 1);
        bus.PB[0] = 1'b1;
        ticks(12);

        // Random activity
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 20);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    bus.PB[c] = ~bus.PB[c];
                    case ($urandom_range(0, 3))
                        0:       rem[c] = $urandom_range(1, 4);
                        1:       rem[c] = $urandom_range(12, 20);
                        2:       rem[c] = $urandom_range(5, 40);
                        default: rem[c] = $urandom_range(1, 8);
                    endcase
                end
            end
            tick();
        end
        bus.PB = 2'b11;
        ticks(12);

        // Reset mid-operation with channel 0 debounce count at 2
        bus.PB[1] = 1'b0;
        ticks(20);
        bus.PB[0] = 1'b0;
        ticks(4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_clear", int'({bus.level, bus.pressed, bus.released, bus.long_press, bus.held_long}), 0);
        model_reset();
        ticks(3);
        rst_n = 1'b1;
        wait_bit(0, 0, n);
        chk("press_after_reset", n, DB + 2);
        bus.PB = 2'b11;
        ticks(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
